// File: rtl/oled_pkg.sv
// Shared constants, opcodes and FSM state for the OLED panel bus.
// Used by oled_rx, its address generator and the testbench.
package oled_pkg;

  localparam int DEF_WIDTH  = 96;
  localparam int DEF_HEIGHT = 64;

  localparam logic [7:0] CMD_SET_COL  = 8'h15;
  localparam logic [7:0] CMD_SET_ROW  = 8'h75;
  localparam logic [7:0] CMD_DISP_ON  = 8'hAF;
  localparam logic [7:0] CMD_DISP_OFF = 8'hAE;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_COL_S,
    ST_COL_E,
    ST_ROW_S,
    ST_ROW_E
  } state_t;

  // Saturate a raw window argument to the panel limit.
  function automatic logic [7:0] clamp8(
    input logic [7:0] v,
    input logic [7:0] lim
  );
    return (v > lim) ? lim : v;
  endfunction

endpackage

// File: rtl/oled_rx_if.sv
// Board-side OLED panel bus: cs/rst active low, dc, e strobe, byte.
// master = the driver (oled), slave = the receiver (oled_rx).
interface oled_rx_if;
  logic       oled_cs;
  logic       oled_rst;
  logic       oled_dc;
  logic       oled_e;
  logic [7:0] oled_dout;

  modport master (
    output oled_cs, oled_rst, oled_dc,
    output oled_e, oled_dout
  );

  modport slave (
    input oled_cs, oled_rst, oled_dc,
    input oled_e, oled_dout
  );
endinterface

// File: rtl/oled_addr_gen.sv
// Column/row window, write pointer with in-window wrap, pixel address.
// Ports: clk/rst, srst_i (panel reset), ld_col_i/ld_row_i, adv_i,
// start_i/end_i (raw window args), addr_o = row*WIDTH + col.
module oled_addr_gen
  import oled_pkg::*;
#(
  parameter int WIDTH  = DEF_WIDTH,
  parameter int HEIGHT = DEF_HEIGHT,
  parameter int ADDR_W = 13
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              srst_i,
  input  logic              ld_col_i,
  input  logic              ld_row_i,
  input  logic              adv_i,
  input  logic [7:0]        start_i,
  input  logic [7:0]        end_i,
  output logic [ADDR_W-1:0] addr_o
);

  localparam logic [7:0] CMAX = 8'(WIDTH - 1);
  localparam logic [7:0] RMAX = 8'(HEIGHT - 1);

  logic [7:0] cs_q, ce_q, rs_q, re_q;
  logic [7:0] col_q, row_q;
  logic [7:0] lim;
  logic [7:0] s_d, e_c, e_d;

  // Shared clamp: only one window loads per cycle.
  always_comb begin
    lim = ld_row_i ? RMAX : CMAX;
    s_d = clamp8(start_i, lim);
    e_c = clamp8(end_i, lim);
    e_d = (e_c < s_d) ? s_d : e_c;
  end

  logic [ADDR_W-1:0] r_w, c_w;
  assign r_w = ADDR_W'(row_q);
  assign c_w = ADDR_W'(col_q);

  generate
    if (WIDTH == 96) begin : g_shift
      assign addr_o = (r_w << 6) + (r_w << 5) + c_w;
    end else begin : g_mul
      assign addr_o = r_w * ADDR_W'(WIDTH) + c_w;
    end
  endgenerate

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cs_q  <= 8'd0;
      ce_q  <= CMAX;
      rs_q  <= 8'd0;
      re_q  <= RMAX;
      col_q <= 8'd0;
      row_q <= 8'd0;
    end else if (srst_i) begin
      cs_q  <= 8'd0;
      ce_q  <= CMAX;
      rs_q  <= 8'd0;
      re_q  <= RMAX;
      col_q <= 8'd0;
      row_q <= 8'd0;
    end else begin
      if (ld_col_i) begin
        cs_q  <= s_d;
        ce_q  <= e_d;
        col_q <= s_d;
      end
      if (ld_row_i) begin
        rs_q  <= s_d;
        re_q  <= e_d;
        row_q <= s_d;
      end
      if (adv_i) begin
        if (col_q == ce_q) begin
          col_q <= cs_q;
          row_q <= (row_q == re_q) ? rs_q
                                   : row_q + 8'd1;
        end else begin
          col_q <= col_q + 8'd1;
        end
      end
    end
  end

endmodule

// File: rtl/oled_rx.sv
// Behavioural OLED panel controller: decodes bus bytes into fb writes.
// Ports: clk, rst, bus (slave), fb_we/fb_addr/fb_data, cmd_*, display_on.
module oled_rx
  import oled_pkg::*;
#(
  parameter int WIDTH  = DEF_WIDTH,
  parameter int HEIGHT = DEF_HEIGHT,
  parameter int ADDR_W = 13
) (
  input  logic              clk,
  input  logic              rst,
  oled_rx_if.slave          bus,
  output logic              fb_we,
  output logic [ADDR_W-1:0] fb_addr,
  output logic [7:0]        fb_data,
  output logic              cmd_valid,
  output logic [7:0]        cmd_byte,
  output logic              display_on
);

  state_t            state_q;
  logic              e_q;
  logic [7:0]        start_q;
  logic              we_q, cv_q, disp_q;
  logic [ADDR_W-1:0] addr_q;
  logic [7:0]        data_q, cb_q;
  logic [ADDR_W-1:0] ptr_addr;

  logic srst, wr, is_cmd, is_dat;
  logic ld_col, ld_row;

  assign srst   = ~bus.oled_rst;
  assign wr     = e_q & ~bus.oled_e & ~bus.oled_cs;
  assign is_cmd = wr & ~bus.oled_dc;
  assign is_dat = wr & bus.oled_dc;
  assign ld_col = is_cmd & (state_q == ST_COL_E);
  assign ld_row = is_cmd & (state_q == ST_ROW_E);

  oled_addr_gen #(
    .WIDTH  (WIDTH),
    .HEIGHT (HEIGHT),
    .ADDR_W (ADDR_W)
  ) u_addr (
    .clk      (clk),
    .rst      (rst),
    .srst_i   (srst),
    .ld_col_i (ld_col),
    .ld_row_i (ld_row),
    .adv_i    (is_dat),
    .start_i  (start_q),
    .end_i    (bus.oled_dout),
    .addr_o   (ptr_addr)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= ST_IDLE;
      e_q     <= 1'b1;
      start_q <= 8'd0;
      we_q    <= 1'b0;
      cv_q    <= 1'b0;
      disp_q  <= 1'b0;
      addr_q  <= '0;
      data_q  <= 8'd0;
      cb_q    <= 8'd0;
    end else if (srst) begin
      state_q <= ST_IDLE;
      e_q     <= 1'b1;
      start_q <= 8'd0;
      we_q    <= 1'b0;
      cv_q    <= 1'b0;
      disp_q  <= 1'b0;
      addr_q  <= '0;
      data_q  <= 8'd0;
      cb_q    <= 8'd0;
    end else begin
      e_q  <= bus.oled_e;
      we_q <= 1'b0;
      cv_q <= 1'b0;
      if (is_dat) begin
        // A pixel aborts any half-finished window command.
        we_q    <= 1'b1;
        addr_q  <= ptr_addr;
        data_q  <= bus.oled_dout;
        state_q <= ST_IDLE;
      end else if (is_cmd) begin
        unique case (state_q)
          ST_IDLE: begin
            if (bus.oled_dout == CMD_SET_COL)
              state_q <= ST_COL_S;
            else if (bus.oled_dout == CMD_SET_ROW)
              state_q <= ST_ROW_S;
            else if (bus.oled_dout == CMD_DISP_ON)
              disp_q <= 1'b1;
            else if (bus.oled_dout == CMD_DISP_OFF)
              disp_q <= 1'b0;
            else begin
              cv_q <= 1'b1;
              cb_q <= bus.oled_dout;
            end
          end
          ST_COL_S: begin
            start_q <= bus.oled_dout;
            state_q <= ST_COL_E;
          end
          ST_ROW_S: begin
            start_q <= bus.oled_dout;
            state_q <= ST_ROW_E;
          end
          ST_COL_E: state_q <= ST_IDLE;
          ST_ROW_E: state_q <= ST_IDLE;
          default:  state_q <= ST_IDLE;
        endcase
      end
    end
  end

  assign fb_we      = we_q;
  assign fb_addr    = addr_q;
  assign fb_data    = data_q;
  assign cmd_valid  = cv_q;
  assign cmd_byte   = cb_q;
  assign display_on = disp_q;

endmodule

// File: tb/tb_oled_rx.sv
// Testbench for oled_rx: directed plan steps plus random byte stream
// checked against a window/pointer model computed from panel rules.
module tb_oled_rx;
  import oled_pkg::*;

  logic        clk = 1'b0;
  logic        rst;
  logic        fb_we, cmd_valid, display_on;
  logic [12:0] fb_addr;
  logic [7:0]  fb_data, cmd_byte;

  int checks = 0;
  int errors = 0;

  oled_rx_if bus ();

  oled_rx dut (
    .clk        (clk),
    .rst        (rst),
    .bus        (bus),
    .fb_we      (fb_we),
    .fb_addr    (fb_addr),
    .fb_data    (fb_data),
    .cmd_valid  (cmd_valid),
    .cmd_byte   (cmd_byte),
    .display_on (display_on)
  );

  always #5 clk = ~clk;

  // Reference model state.
  int m_cs, m_ce, m_rs, m_re;
  int m_col, m_row, m_st, m_pend;
  int m_disp, m_addr, m_data, m_cb;

  task automatic m_reset();
    m_cs = 0; m_ce = 95; m_rs = 0; m_re = 63;
    m_col = 0; m_row = 0; m_st = 0; m_pend = 0;
    m_disp = 0; m_addr = 0; m_data = 0; m_cb = 0;
  endtask

  function automatic int lim(int v, int mx);
    return (v > mx) ? mx : v;
  endfunction

  task automatic chk(string tag, logic [31:0] obs,
                     logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h",
             tag, obs, exp);
    end
  endtask

  task automatic chk_idle_out(string tag);
    chk({tag, "_we0"}, 32'(fb_we), 0);
    chk({tag, "_cv0"}, 32'(cmd_valid), 0);
  endtask

  // One bus write at max rate; exp_addr >= 0 adds a fixed check.
  task automatic wr(input bit dc, input logic [7:0] b,
                    input int exp_addr = -1);
    int e_we, e_cv, s, e;
    e_we = 0; e_cv = 0;
    if (dc) begin
      e_we = 1;
      m_addr = m_row * 96 + m_col;
      m_data = b;
      if (m_col == m_ce) begin
        m_col = m_cs;
        m_row = (m_row == m_re) ? m_rs : m_row + 1;
      end else m_col++;
      m_st = 0;
    end else begin
      case (m_st)
        0: begin
          if (b == CMD_SET_COL) m_st = 1;
          else if (b == CMD_SET_ROW) m_st = 3;
          else if (b == CMD_DISP_ON) m_disp = 1;
          else if (b == CMD_DISP_OFF) m_disp = 0;
          else begin e_cv = 1; m_cb = b; end
        end
        1, 3: begin m_pend = b; m_st++; end
        2: begin
          s = lim(m_pend, 95); e = lim(b, 95);
          if (e < s) e = s;
          m_cs = s; m_ce = e; m_col = s; m_st = 0;
        end
        default: begin
          s = lim(m_pend, 63); e = lim(b, 63);
          if (e < s) e = s;
          m_rs = s; m_re = e; m_row = s; m_st = 0;
        end
      endcase
    end
    @(negedge clk);
    bus.oled_e = 1'b0;
    bus.oled_dc = dc;
    bus.oled_dout = b;
    @(posedge clk); #1;
    chk("fb_we", 32'(fb_we), e_we);
    chk("cmd_valid", 32'(cmd_valid), e_cv);
    chk("fb_addr", 32'(fb_addr), m_addr);
    chk("fb_data", 32'(fb_data), m_data);
    chk("cmd_byte", 32'(cmd_byte), m_cb);
    chk("display_on", 32'(display_on), m_disp);
    if (exp_addr >= 0)
      chk("plan_addr", 32'(fb_addr), exp_addr);
    @(negedge clk);
    bus.oled_e = 1'b1;
    @(posedge clk); #1;
    chk_idle_out("gap");
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst = 1'b1;
    repeat (2) @(negedge clk);
    rst = 1'b0;
    m_reset();
    @(posedge clk); #1;
    chk("rst_we", 32'(fb_we), 0);
    chk("rst_addr", 32'(fb_addr), 0);
    chk("rst_data", 32'(fb_data), 0);
    chk("rst_cv", 32'(cmd_valid), 0);
    chk("rst_cb", 32'(cmd_byte), 0);
    chk("rst_disp", 32'(display_on), 0);
  endtask

  initial begin
    int r;
    rst = 1'b1;
    bus.oled_cs = 1'b0;
    bus.oled_rst = 1'b1;
    bus.oled_dc = 1'b0;
    bus.oled_e = 1'b1;
    bus.oled_dout = 8'h00;
    m_reset();
    repeat (3) @(posedge clk);
    do_reset();

    // Three pixels from reset.
    wr(1, 8'h11, 0);
    wr(1, 8'h22, 1);
    wr(1, 8'h33, 2);

    // Window 2..4 x 1..2 and wrap.
    do_reset();
    wr(0, 8'h15); wr(0, 8'h02); wr(0, 8'h04);
    wr(0, 8'h75); wr(0, 8'h01); wr(0, 8'h02);
    wr(1, 8'h01, 98);  wr(1, 8'h02, 99);
    wr(1, 8'h03, 100); wr(1, 8'h04, 194);
    wr(1, 8'h05, 195); wr(1, 8'h06, 196);
    wr(1, 8'h07, 98);

    // Clamped single-column window.
    do_reset();
    wr(0, 8'h15); wr(0, 8'h70); wr(0, 8'h05);
    wr(1, 8'hA1, 95);
    wr(1, 8'hA2, 191);

    // Display and unhandled commands.
    wr(0, 8'hAF);
    chk("disp_on", 32'(display_on), 1);
    wr(0, 8'hAE);
    chk("disp_off", 32'(display_on), 0);
    wr(0, 8'hA0);

    // Aborted column command.
    do_reset();
    wr(0, 8'h15); wr(0, 8'h05);
    wr(1, 8'h7E, 0);
    wr(1, 8'h01, 1); wr(1, 8'h02, 2);
    wr(1, 8'h03, 3); wr(1, 8'h04, 4);

    // Panel reset with an edge during it.
    wr(0, 8'hAF);
    wr(1, 8'h55);
    @(negedge clk);
    bus.oled_rst = 1'b0;
    @(negedge clk);
    bus.oled_e = 1'b0;
    bus.oled_dc = 1'b1;
    @(posedge clk); #1;
    chk_idle_out("prst1");
    @(negedge clk);
    bus.oled_e = 1'b1;
    @(posedge clk); #1;
    chk_idle_out("prst2");
    @(negedge clk);
    bus.oled_rst = 1'b1;
    m_reset();
    @(posedge clk); #1;
    chk("prst_disp", 32'(display_on), 0);
    chk("prst_addr", 32'(fb_addr), 0);
    wr(1, 8'h99, 0);

    // Chip-select high: edges ignored.
    @(negedge clk);
    bus.oled_cs = 1'b1;
    bus.oled_e = 1'b0;
    bus.oled_dc = 1'b1;
    @(posedge clk); #1;
    chk_idle_out("cs1");
    @(negedge clk);
    bus.oled_e = 1'b1;
    @(posedge clk); #1;
    chk_idle_out("cs2");
    @(negedge clk);
    bus.oled_cs = 1'b0;
    wr(1, 8'h42, 1);

    // Random stream.
    for (int i = 0; i < 300; i++) begin
      r = $urandom_range(0, 11);
      if (r <= 5) begin
        wr(1, 8'($urandom));
      end else if (r == 6 || r == 7) begin
        wr(0, (r == 6) ? CMD_SET_COL : CMD_SET_ROW);
        wr(0, 8'($urandom_range(0, 127)));
        wr(0, 8'($urandom_range(0, 127)));
      end else if (r == 8) begin
        wr(0, $urandom_range(0, 1) ? CMD_DISP_ON
                                   : CMD_DISP_OFF);
      end else if (r == 9) begin
        wr(0, 8'($urandom));
      end else if (r == 10) begin
        wr(0, CMD_SET_ROW);
        wr(0, 8'($urandom_range(0, 127)));
        wr(1, 8'($urandom));
      end else begin
        wr(0, CMD_SET_COL);
        wr(1, 8'($urandom));
      end
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
